// File: rtl/dma_queue_controller.sv
// Register-programmed descriptor-pair FIFO that issues MM2S/S2MM command pairs to an AXI DataMover.
// Optional level interrupt is built when DMA_QUEUE_CTRL_IRQ_EN is defined.
module dma_queue_controller #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXI_TAG_WIDTH   = 8,
    parameter int AXIS_USER_WIDTH = 65,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    reg_wr_en,
    input  logic                                    reg_rd_en,
    input  logic [AXI_ADDR_WIDTH-1:0]               reg_wr_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]               reg_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]               reg_wr_data,
    output logic [AXI_DATA_WIDTH-1:0]               reg_rd_data,
    output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc,
    output logic [AXIS_USER_WIDTH-1:0]              mm2s_user,
    output logic                                    mm2s_valid,
    input  logic                                    mm2s_ready,
    input  logic [3:0]                              mm2s_status_error,
    input  logic                                    mm2s_status_valid,
    output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc,
    output logic [AXI_TAG_WIDTH-1:0]                s2mm_tag,
    output logic                                    s2mm_valid,
    input  logic                                    s2mm_ready,
    input  logic [3:0]                              s2mm_status_error,
    input  logic                                    s2mm_status_valid,
    output logic                                    irq
);
    localparam int DESC_WIDTH = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] A_CTRL   = AXI_ADDR_WIDTH'(3'd0);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_STATUS = AXI_ADDR_WIDTH'(3'd1);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_MADDR  = AXI_ADDR_WIDTH'(3'd2);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_MLEN   = AXI_ADDR_WIDTH'(3'd3);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_TUSER  = AXI_ADDR_WIDTH'(3'd4);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_SADDR  = AXI_ADDR_WIDTH'(3'd5);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_SLEN   = AXI_ADDR_WIDTH'(3'd6);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_DCNT   = AXI_ADDR_WIDTH'(3'd7);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;
    state_t state_r, state_nxt_s;

    logic [AXI_ADDR_WIDTH-1:0] stg_maddr_r, stg_saddr_r;
    logic [AXI_LEN_WIDTH-1:0]  stg_mlen_r, stg_slen_r;
    logic [AXI_DATA_WIDTH-1:0] stg_tuser_r;
    logic [AXI_ADDR_WIDTH-1:0] q_maddr [QUEUE_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] q_saddr [QUEUE_DEPTH];
    logic [AXI_LEN_WIDTH-1:0]  q_mlen  [QUEUE_DEPTH];
    logic [AXI_LEN_WIDTH-1:0]  q_slen  [QUEUE_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] q_tuser [QUEUE_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic [AXI_TAG_WIDTH-1:0]  tag_cnt_r;
    logic [AXI_DATA_WIDTH-1:0] done_count_r, rd_mux_s, reg_rd_data_r;
    logic [DESC_WIDTH-1:0]     mm2s_desc_r, s2mm_desc_r;
    logic [AXIS_USER_WIDTH-1:0] mm2s_user_r;
    logic [AXI_TAG_WIDTH-1:0]  s2mm_tag_r;
    logic mm2s_valid_r, s2mm_valid_r, got_m_r, got_s_r, ovf_r, err_r;
    logic [3:0] cur_merr_r, cur_serr_r, last_merr_r, last_serr_r;
    logic [31:0] status_s, ctrl_rd_s;
    logic wr_ctrl_s, push_s, clear_s, full_s, empty_s, push_ok_s, pop_s;
    logic capture_s, done_s, issue_done_s;

    assign wr_ctrl_s    = reg_wr_en && (reg_wr_addr == A_CTRL);
    assign push_s       = wr_ctrl_s && reg_wr_data[0];
    assign clear_s      = wr_ctrl_s && reg_wr_data[1];
    assign full_s       = (count_r == CNT_W'(QUEUE_DEPTH));
    assign empty_s      = (count_r == '0);
    assign push_ok_s    = push_s && !full_s;
    assign pop_s        = (state_r == S_IDLE) && !empty_s;
    assign capture_s    = (state_r == S_ISSUE) || (state_r == S_WAIT);
    assign done_s       = (state_r == S_DONE);
    // A channel's handshake is complete once its valid is low or is being accepted this cycle
    assign issue_done_s = (!mm2s_valid_r || mm2s_ready) && (!s2mm_valid_r || s2mm_ready);

    // Staging registers, written by software and copied into the queue on PUSH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_maddr_r <= '0; stg_mlen_r <= '0; stg_tuser_r <= '0;
            stg_saddr_r <= '0; stg_slen_r <= '0;
        end else if (reg_wr_en) begin
            case (reg_wr_addr)
                A_MADDR: stg_maddr_r <= AXI_ADDR_WIDTH'(reg_wr_data);
                A_MLEN:  stg_mlen_r  <= AXI_LEN_WIDTH'(reg_wr_data);
                A_TUSER: stg_tuser_r <= reg_wr_data;
                A_SADDR: stg_saddr_r <= AXI_ADDR_WIDTH'(reg_wr_data);
                A_SLEN:  stg_slen_r  <= AXI_LEN_WIDTH'(reg_wr_data);
                default: ;
            endcase
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            q_maddr[wr_ptr_r] <= stg_maddr_r; q_mlen[wr_ptr_r] <= stg_mlen_r;
            q_tuser[wr_ptr_r] <= stg_tuser_r;
            q_saddr[wr_ptr_r] <= stg_saddr_r; q_slen[wr_ptr_r] <= stg_slen_r;
        end
    end

    // Queue pointers and occupancy; a full queue drops the push even when popping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0; rd_ptr_r <= '0; count_r <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= S_IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (!empty_s) state_nxt_s = S_ISSUE; else state_nxt_s = S_IDLE;
            S_ISSUE: if (issue_done_s) state_nxt_s = S_WAIT; else state_nxt_s = S_ISSUE;
            S_WAIT:  if ((got_m_r || mm2s_status_valid) && (got_s_r || s2mm_status_valid))
                         state_nxt_s = S_DONE;
                     else
                         state_nxt_s = S_WAIT;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Command outputs: loaded on pop, each valid dropped on its own handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm2s_desc_r <= '0; s2mm_desc_r <= '0; mm2s_user_r <= '0; s2mm_tag_r <= '0;
            mm2s_valid_r <= 1'b0; s2mm_valid_r <= 1'b0;
        end else if (pop_s) begin
            mm2s_desc_r  <= {q_mlen[rd_ptr_r], q_maddr[rd_ptr_r]};
            s2mm_desc_r  <= {q_slen[rd_ptr_r], q_saddr[rd_ptr_r]};
            mm2s_user_r  <= AXIS_USER_WIDTH'(q_tuser[rd_ptr_r]);
            s2mm_tag_r   <= tag_cnt_r;
            mm2s_valid_r <= 1'b1;
            s2mm_valid_r <= 1'b1;
        end else begin
            if (mm2s_valid_r && mm2s_ready) mm2s_valid_r <= 1'b0;
            if (s2mm_valid_r && s2mm_ready) s2mm_valid_r <= 1'b0;
        end
    end

    // Per-channel completion capture, only while a pair is outstanding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            got_m_r <= 1'b0; got_s_r <= 1'b0; cur_merr_r <= 4'd0; cur_serr_r <= 4'd0;
        end else if (pop_s) begin
            got_m_r <= 1'b0; got_s_r <= 1'b0; cur_merr_r <= 4'd0; cur_serr_r <= 4'd0;
        end else if (capture_s) begin
            if (mm2s_status_valid && !got_m_r) begin got_m_r <= 1'b1; cur_merr_r <= mm2s_status_error; end
            if (s2mm_status_valid && !got_s_r) begin got_s_r <= 1'b1; cur_serr_r <= s2mm_status_error; end
        end
    end

    // Completion bookkeeping; CLEAR overrides a coincident DONE, the tag counter is never cleared
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_count_r <= '0; tag_cnt_r <= '0; ovf_r <= 1'b0; err_r <= 1'b0;
            last_merr_r <= 4'd0; last_serr_r <= 4'd0;
        end else begin
            if (done_s) tag_cnt_r <= tag_cnt_r + AXI_TAG_WIDTH'(1'b1);
            if (clear_s) begin
                done_count_r <= '0; ovf_r <= 1'b0; err_r <= 1'b0;
                last_merr_r <= 4'd0; last_serr_r <= 4'd0;
            end else begin
                if (push_s && full_s) ovf_r <= 1'b1;
                if (done_s) begin
                    done_count_r <= done_count_r + AXI_DATA_WIDTH'(1'b1);
                    last_merr_r  <= cur_merr_r;
                    last_serr_r  <= cur_serr_r;
                    if ((cur_merr_r != 4'd0) || (cur_serr_r != 4'd0)) err_r <= 1'b1;
                end
            end
        end
    end

`ifdef DMA_QUEUE_CTRL_IRQ_EN
    logic irq_en_r, irq_en_nxt_s, pend_r, pend_nxt_s, irq_r;

    // Every CTRL write rewrites IRQ_EN; a completion beats a coincident IRQ_ACK
    always_comb begin
        irq_en_nxt_s = irq_en_r;
        pend_nxt_s   = pend_r;
        if (wr_ctrl_s) irq_en_nxt_s = reg_wr_data[2];
        else           irq_en_nxt_s = irq_en_r;
        if (done_s)                           pend_nxt_s = 1'b1;
        else if (wr_ctrl_s && reg_wr_data[3]) pend_nxt_s = 1'b0;
        else                                  pend_nxt_s = pend_r;
    end

    // Interrupt enable, pending flag and registered irq
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en_r <= 1'b0; pend_r <= 1'b0; irq_r <= 1'b0;
        end else begin
            irq_en_r <= irq_en_nxt_s;
            pend_r   <= pend_nxt_s;
            irq_r    <= irq_en_nxt_s & pend_nxt_s;
        end
    end

    assign irq       = irq_r;
    assign ctrl_rd_s = {29'd0, irq_en_r, 2'd0};
`else
    assign irq       = 1'b0;
    assign ctrl_rd_s = 32'd0;
`endif

    assign status_s = {8'd0, last_serr_r, last_merr_r, 8'(count_r), 3'd0, err_r, ovf_r,
                       empty_s, full_s, (state_r != S_IDLE) || !empty_s};

    // Register read decode
    always_comb begin
        rd_mux_s = '0;
        case (reg_rd_addr)
            A_CTRL:   rd_mux_s = AXI_DATA_WIDTH'(ctrl_rd_s);
            A_STATUS: rd_mux_s = AXI_DATA_WIDTH'(status_s);
            A_MADDR:  rd_mux_s = AXI_DATA_WIDTH'(stg_maddr_r);
            A_MLEN:   rd_mux_s = AXI_DATA_WIDTH'(stg_mlen_r);
            A_TUSER:  rd_mux_s = stg_tuser_r;
            A_SADDR:  rd_mux_s = AXI_DATA_WIDTH'(stg_saddr_r);
            A_SLEN:   rd_mux_s = AXI_DATA_WIDTH'(stg_slen_r);
            A_DCNT:   rd_mux_s = done_count_r;
            default:  rd_mux_s = '0;
        endcase
    end

    // Read data register, holds between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          reg_rd_data_r <= '0;
        else if (reg_rd_en) reg_rd_data_r <= rd_mux_s;
    end

    assign reg_rd_data = reg_rd_data_r;
    assign mm2s_desc   = mm2s_desc_r;
    assign mm2s_user   = mm2s_user_r;
    assign mm2s_valid  = mm2s_valid_r;
    assign s2mm_desc   = s2mm_desc_r;
    assign s2mm_tag    = s2mm_tag_r;
    assign s2mm_valid  = s2mm_valid_r;
endmodule
